// File: rtl/gimbal_step_scheduler_pkg.sv
// Shared types and widths for the gimbal step scheduler.
//   state_t  : scheduler FSM states
//   target_t : locked target centre coordinates from the lock-on controller
package gimbal_step_scheduler_pkg;

   localparam int unsigned POS_W        = 10;   // pixel coordinate width
   localparam int unsigned ERR_W        = 11;   // signed offset from screen centre
   localparam int unsigned CNT_W        = 5;    // per-frame step counter width
   localparam int unsigned TIMER_W      = 16;   // shared phase timer width
   localparam int unsigned CENTER_X_DEF = 320;
   localparam int unsigned CENTER_Y_DEF = 240;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_DIR_SETUP,
      S_STEP_HI,
      S_STEP_LO,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
   } target_t;

endpackage

// File: rtl/gimbal_step_scheduler_if.sv
// Tracker-to-scheduler and scheduler-to-driver signal bundle.
//   master : lock-on controller side (drives frame/target info, observes motor commands)
//   slave  : scheduler side (consumes frame/target info, drives STEP/DIR and status)
interface gimbal_step_scheduler_if;
   import gimbal_step_scheduler_pkg::*;

   logic    frame_tick;
   logic    is_locked;
   logic    target_valid;
   logic    center_hit;
   target_t target;

   logic    pan_step;
   logic    pan_dir;
   logic    tilt_step;
   logic    tilt_dir;
   logic    motor_en;
   logic    busy;
   logic    move_done;
   logic    frame_overrun;

   modport master (
      output frame_tick, is_locked, target_valid, center_hit, target,
      input  pan_step, pan_dir, tilt_step, tilt_dir, motor_en, busy, move_done, frame_overrun
   );

   modport slave (
      input  frame_tick, is_locked, target_valid, center_hit, target,
      output pan_step, pan_dir, tilt_step, tilt_dir, motor_en, busy, move_done, frame_overrun
   );

endinterface

// File: rtl/axis_step_calc.sv
// Per-axis combinational step planner: offset from centre -> direction and step count.
//   target     : target coordinate on this axis (px)
//   center_hit : target already inside the centre window, forces zero steps
//   dir        : 1 when the offset is positive (XOR INVERT)
//   count      : deadbanded, gain-scaled, saturated step count for this frame
module axis_step_calc
   import gimbal_step_scheduler_pkg::*;
#(
   parameter int unsigned CENTER     = 320,
   parameter int unsigned DEADBAND   = 16,
   parameter int unsigned GAIN_SHIFT = 3,
   parameter int unsigned MAX_STEPS  = 31,
   parameter bit          INVERT     = 1'b0
) (
   input  logic [POS_W-1:0] target,
   input  logic             center_hit,
   output logic             dir,
   output logic [CNT_W-1:0] count
);

   localparam logic [ERR_W-1:0] CTR  = ERR_W'(CENTER);
   localparam logic [ERR_W-1:0] DB   = ERR_W'(DEADBAND);
   localparam logic [ERR_W-1:0] MAXS = ERR_W'(MAX_STEPS);

   logic signed [ERR_W-1:0] err;
   logic        [ERR_W-1:0] mag;
   logic        [ERR_W-1:0] steps;

   always_comb begin
      err   = $signed({1'b0, target}) - $signed(CTR);
      mag   = $unsigned(err[ERR_W-1] ? -err : err);
      // Subtraction may wrap inside the deadband; that case is forced to zero below.
      steps = (mag - DB) >> GAIN_SHIFT;
      if (steps == '0)  steps = ERR_W'(1);
      if (steps > MAXS) steps = MAXS;
      if (center_hit || (mag <= DB)) steps = '0;
      count = CNT_W'(steps);
      dir   = (~err[ERR_W-1] & (|err)) ^ INVERT;
   end

endmodule

// File: rtl/gimbal_step_scheduler.sv
// Per-frame pan/tilt stepper scheduler: latches the target offset on frame_tick and
// plays out concurrent STEP/DIR pulse trains on both axes using one shared timer.
//   clk, reset : system clock, synchronous active-high reset
//   bus.slave  : frame_tick/is_locked/target_valid/center_hit/target in;
//                pan_step/pan_dir/tilt_step/tilt_dir/motor_en/busy/move_done/frame_overrun out
module gimbal_step_scheduler
   import gimbal_step_scheduler_pkg::*;
#(
   parameter int unsigned CENTER_X    = CENTER_X_DEF,
   parameter int unsigned CENTER_Y    = CENTER_Y_DEF,
   parameter int unsigned DEADBAND    = 16,
   parameter int unsigned GAIN_SHIFT  = 3,
   parameter int unsigned MAX_STEPS   = 31,
   parameter int unsigned DIR_SETUP   = 200,
   parameter int unsigned STEP_HIGH   = 500,
   parameter int unsigned STEP_PERIOD = 50000,
   parameter bit          INVERT_PAN  = 1'b0,
   parameter bit          INVERT_TILT = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   gimbal_step_scheduler_if.slave  bus
);

   // Terminal timer values for each timed phase.
   localparam logic [TIMER_W-1:0] T_DIR = TIMER_W'(DIR_SETUP - 1);
   localparam logic [TIMER_W-1:0] T_HI  = TIMER_W'(STEP_HIGH - 1);
   localparam logic [TIMER_W-1:0] T_LO  = TIMER_W'(STEP_PERIOD - STEP_HIGH - 1);

   state_t             state, state_nxt;
   logic [TIMER_W-1:0] timer, timer_nxt;
   logic [CNT_W-1:0]   pan_cnt, tilt_cnt, pan_cnt_nxt, tilt_cnt_nxt;
   logic [CNT_W-1:0]   pan_calc_cnt, tilt_calc_cnt;
   logic               pan_calc_dir, tilt_calc_dir;

   logic pan_step_q, pan_dir_q, tilt_step_q, tilt_dir_q;
   logic motor_en_q, busy_q, move_done_q, overrun_q;
   logic pan_step_nxt, pan_dir_nxt, tilt_step_nxt, tilt_dir_nxt;
   logic motor_en_nxt, busy_nxt, move_done_nxt, overrun_nxt;

   axis_step_calc #(
      .CENTER(CENTER_X), .DEADBAND(DEADBAND), .GAIN_SHIFT(GAIN_SHIFT),
      .MAX_STEPS(MAX_STEPS), .INVERT(INVERT_PAN)
   ) u_pan_calc (
      .target(bus.target.x), .center_hit(bus.center_hit),
      .dir(pan_calc_dir), .count(pan_calc_cnt)
   );

   axis_step_calc #(
      .CENTER(CENTER_Y), .DEADBAND(DEADBAND), .GAIN_SHIFT(GAIN_SHIFT),
      .MAX_STEPS(MAX_STEPS), .INVERT(INVERT_TILT)
   ) u_tilt_calc (
      .target(bus.target.y), .center_hit(bus.center_hit),
      .dir(tilt_calc_dir), .count(tilt_calc_cnt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; losing lock aborts, except that a running STEP high phase finishes.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (bus.frame_tick && bus.is_locked && bus.target_valid) state_nxt = S_LATCH;
         S_LATCH:
            if (!bus.is_locked || ((pan_calc_cnt == '0) && (tilt_calc_cnt == '0)))
               state_nxt = S_IDLE;
            else
               state_nxt = S_DIR_SETUP;
         S_DIR_SETUP:
            if (!bus.is_locked)  state_nxt = S_IDLE;
            else if (timer == T_DIR) state_nxt = S_STEP_HI;
         S_STEP_HI:
            if (timer == T_HI) state_nxt = bus.is_locked ? S_STEP_LO : S_IDLE;
         S_STEP_LO:
            if (!bus.is_locked) state_nxt = S_IDLE;
            else if (timer == T_LO)
               state_nxt = ((pan_cnt == '0) && (tilt_cnt == '0)) ? S_DONE : S_STEP_HI;
         S_DONE:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Datapath and output next values; outputs are registered from the next state.
   always_comb begin
      timer_nxt     = timer + TIMER_W'(1);
      pan_cnt_nxt   = pan_cnt;
      tilt_cnt_nxt  = tilt_cnt;
      pan_dir_nxt   = pan_dir_q;
      tilt_dir_nxt  = tilt_dir_q;

      if ((state_nxt != state) || (state_nxt == S_IDLE)) timer_nxt = '0;

      if (state == S_LATCH) begin
         pan_cnt_nxt  = pan_calc_cnt;
         tilt_cnt_nxt = tilt_calc_cnt;
         if (state_nxt == S_DIR_SETUP) begin
            pan_dir_nxt  = pan_calc_dir;
            tilt_dir_nxt = tilt_calc_dir;
         end
      end

      // A pulse is accounted for when its high phase ends.
      if ((state == S_STEP_HI) && (state_nxt != S_STEP_HI)) begin
         if (pan_cnt  != '0) pan_cnt_nxt  = pan_cnt  - CNT_W'(1);
         if (tilt_cnt != '0) tilt_cnt_nxt = tilt_cnt - CNT_W'(1);
      end

      if (state_nxt == S_IDLE) begin
         pan_cnt_nxt  = '0;
         tilt_cnt_nxt = '0;
      end

      pan_step_nxt  = (state_nxt == S_STEP_HI) && (pan_cnt_nxt  != '0);
      tilt_step_nxt = (state_nxt == S_STEP_HI) && (tilt_cnt_nxt != '0);
      busy_nxt      = (state_nxt != S_IDLE);
      motor_en_nxt  = bus.is_locked | busy_nxt;
      move_done_nxt = (state_nxt == S_DONE);
      overrun_nxt   = bus.frame_tick && (state != S_IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer       <= '0;
         pan_cnt     <= '0;
         tilt_cnt    <= '0;
         pan_step_q  <= 1'b0;
         pan_dir_q   <= 1'b0;
         tilt_step_q <= 1'b0;
         tilt_dir_q  <= 1'b0;
         motor_en_q  <= 1'b0;
         busy_q      <= 1'b0;
         move_done_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         timer       <= timer_nxt;
         pan_cnt     <= pan_cnt_nxt;
         tilt_cnt    <= tilt_cnt_nxt;
         pan_step_q  <= pan_step_nxt;
         pan_dir_q   <= pan_dir_nxt;
         tilt_step_q <= tilt_step_nxt;
         tilt_dir_q  <= tilt_dir_nxt;
         motor_en_q  <= motor_en_nxt;
         busy_q      <= busy_nxt;
         move_done_q <= move_done_nxt;
         overrun_q   <= overrun_nxt;
      end
   end

   assign bus.pan_step      = pan_step_q;
   assign bus.pan_dir       = pan_dir_q;
   assign bus.tilt_step     = tilt_step_q;
   assign bus.tilt_dir      = tilt_dir_q;
   assign bus.motor_en      = motor_en_q;
   assign bus.busy          = busy_q;
   assign bus.move_done     = move_done_q;
   assign bus.frame_overrun = overrun_q;

endmodule
